gray_bin_stream: RTL and testbench
==================================

Name: gray_bin_stream

Overview:
- Parametrised, registered, bidirectional Gray/binary code converter with a valid/ready stream interface.
- Successor to the fixed 3-bit combinational Gray-to-binary converter:
  - generalised width;
  - run-time direction select per word;
  - backpressure;
  - optional Gray-adjacency checking.
- Sits between a Gray-coded source (encoder, async-FIFO pointer, counter) and binary consumers, or the reverse.

Parameters:
- WIDTH, 3, data word width in bits; legal range 2..32; bit WIDTH-1 is the MSB.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  source has a word on in_data.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to convert.
- in_mode  input  1  0 = Gray->binary, 1 = binary->Gray; sampled with in_data.
- out_valid  output  1  out_data holds a converted word.
- out_ready  input  1  sink accepts out_data this cycle.
- out_data  output  WIDTH  converted word.
- out_mode  output  1  mode the out_data word was converted with.
- out_adj_err  output  1  per-word adjacency error flag; present only with the feature enabled, see Optional Feature.
- err_sticky  output  1  sticky OR of out_adj_err; tied 0 when the feature is disabled.
- clr  input  1  synchronous clear of err_sticky and the adjacency history.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_mode=0, out_adj_err=0, err_sticky=0, history invalid. in_ready=1 after reset.
- Transfers:
  - Input transfer: in_valid & in_ready at a rising clk edge.
  - Output transfer: out_valid & out_ready at a rising clk edge.
- in_ready = !out_valid | out_ready (combinational). This gives a single output register with a full-throughput pass-through. No combinational path from in_valid to in_ready.
- Latency: exactly 1 cycle; a word accepted at edge N appears on out_data after edge N.
- Throughput: 1 word/cycle while out_ready=1.
- On input transfer:
  - out_data <= conv(in_data, in_mode);
  - out_mode <= in_mode;
  - out_valid <= 1.
- Output transfer with no input transfer: out_valid <= 0; out_data holds its last value.
- Simultaneous input and output transfer: the new word replaces the old one and out_valid stays 1.
- While out_valid=1 & out_ready=0: out_data, out_mode and out_adj_err are held stable; in_ready=0.
- Gray->binary: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i down to 0 (prefix XOR from the MSB).
- Binary->Gray: g = b ^ (b>>1).
- in_mode may change on any word; there is no drain or bubble on a direction change.
- Mid-operation reset drops any held word immediately; out_valid=0 asynchronously.

Optional Feature:
- Macro: GRAY_ADJ_CHECK_EN.
- Enabled:
  - A history register stores the last Gray word accepted with in_mode=0, plus a history-valid bit.
  - On a mode-0 input transfer with history valid, out_adj_err <= 1 unless popcount(in_data ^ history) == 1. An identical repeated word is an error.
  - The history then updates to in_data.
  - The first mode-0 word after reset/clr is never flagged.
  - A mode-1 transfer sets out_adj_err <= 0 and invalidates history.
  - err_sticky <= err_sticky | (out_adj_err set on this transfer).
  - clr=1 clears err_sticky and invalidates history. If clr coincides with an input transfer, that word is not checked and becomes the new history.
- Disabled:
  - No history logic; out_adj_err is not a port; err_sticky is tied 0.
  - clr is ignored.

Test Plan:
- Reset, WIDTH=3: assert rst_n=0 mid-cycle -> out_valid=0, out_data=000, err_sticky=0 without waiting for clk; in_ready=1 after release.
- Mode 0, out_ready=1: stream 000,001,011,010,110,111,101,100 back-to-back -> out_data 0,1,2,3,4,5,6,7 one cycle later each, out_valid continuous, out_adj_err=0 throughout.
- Mode 1 and mixed direction: binary 101 then 011 with out_mode following -> out_data 111 then 010. Then Gray 100 in mode 0 -> out_data 111.
- Backpressure: hold out_ready=0 for 3 cycles while out_data=101 -> in_ready=0, out_data stays 101. Release out_ready with in_valid=1 and in_data=110 (mode 0) -> 100 is presented on the next cycle with no word lost or duplicated.
- Adjacency (GRAY_ADJ_CHECK_EN): mode 0 sequence 000, 011 -> second output has out_adj_err=1 and err_sticky=1 afterwards. Pulse clr, then send 011 -> out_adj_err=0. Sending 011 again -> out_adj_err=1.
- WIDTH=8, mode 0 random walk of 256 single-bit-flip Gray words -> out_data matches the reference prefix XOR on every word. Round-trip conv(conv(x,1),0)==x for all 256 values.

Source files
------------

// File: rtl/gray_bin_stream_if.sv
// rtl/gray_bin_stream_if.sv - input/output stream bundle for gray_bin_stream (out_adj_err only with GRAY_ADJ_CHECK_EN)
interface gray_bin_stream_if #(
    parameter int WIDTH = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;
`ifdef GRAY_ADJ_CHECK_EN
    logic             out_adj_err;
`endif

    modport master (
        output in_valid, in_data, in_mode, out_ready,
`ifdef GRAY_ADJ_CHECK_EN
        input  out_adj_err,
`endif
        input  in_ready, out_valid, out_data, out_mode
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
`ifdef GRAY_ADJ_CHECK_EN
        output out_adj_err,
`endif
        output in_ready, out_valid, out_data, out_mode
    );
endinterface

// File: rtl/gray_bin_stream.sv
// rtl/gray_bin_stream.sv - registered Gray<->binary stream converter; GRAY_ADJ_CHECK_EN adds Gray adjacency checking
module gray_bin_stream #(
    parameter int WIDTH = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    output logic            err_sticky,
    gray_bin_stream_if.slave s
);
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_mode_q, out_mode_d;
    logic             in_fire;
    logic             out_fire;

    // mode 0: prefix XOR from the MSB (Gray->binary); mode 1: b ^ (b >> 1)
    function automatic logic [WIDTH-1:0] conv(input logic [WIDTH-1:0] w, input logic mode);
        logic [WIDTH-1:0] r;
        r = '0;
        if (mode) begin
            r = w ^ (w >> 1);
        end else begin
            r[WIDTH-1] = w[WIDTH-1];
            for (int i = WIDTH - 2; i >= 0; i--) begin
                r[i] = r[i+1] ^ w[i];
            end
        end
        return r;
    endfunction

    assign s.in_ready  = !out_valid_q | s.out_ready;
    assign in_fire     = s.in_valid & s.in_ready;
    assign out_fire    = out_valid_q & s.out_ready;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_mode  = out_mode_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mode_d  = out_mode_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = conv(s.in_data, s.in_mode);
            out_mode_d  = s.in_mode;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mode_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mode_q  <= out_mode_d;
        end
    end

`ifdef GRAY_ADJ_CHECK_EN
    logic [WIDTH-1:0] hist_q, hist_d;
    logic             hist_valid_q, hist_valid_d;
    logic             adj_err_q, adj_err_d;
    logic             sticky_q, sticky_d;

    always_comb begin
        hist_d       = hist_q;
        hist_valid_d = hist_valid_q;
        adj_err_d    = adj_err_q;
        sticky_d     = sticky_q;
        if (in_fire) begin
            if (s.in_mode) begin
                adj_err_d    = 1'b0;
                hist_valid_d = 1'b0;
            end else begin
                // a word arriving together with clr seeds the history unchecked
                adj_err_d    = hist_valid_q && !clr && ($countones(s.in_data ^ hist_q) != 1);
                hist_d       = s.in_data;
                hist_valid_d = 1'b1;
            end
        end
        if (clr) begin
            sticky_d = 1'b0;
            if (!(in_fire && !s.in_mode)) begin
                hist_valid_d = 1'b0;
            end
        end else if (in_fire && adj_err_d) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q       <= '0;
            hist_valid_q <= 1'b0;
            adj_err_q    <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            hist_q       <= hist_d;
            hist_valid_q <= hist_valid_d;
            adj_err_q    <= adj_err_d;
            sticky_q     <= sticky_d;
        end
    end

    assign s.out_adj_err = adj_err_q;
    assign err_sticky    = sticky_q;
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign err_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_gray_bin_stream.sv
// tb/tb_gray_bin_stream.sv - bench for gray_bin_stream: directed WIDTH=3 cases and randomized WIDTH=8 traffic against a reference model
`timescale 1ns/1ps
module tb_gray_bin_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic sticky_a, sticky_b;
    logic adj_a, adj_b;
    int   total = 0;
    int   bad = 0;

    gray_bin_stream_if #(.WIDTH(3)) ifa ();
    gray_bin_stream_if #(.WIDTH(8)) ifb ();

    gray_bin_stream #(.WIDTH(3)) dut_a (.clk(clk), .rst_n(rst_n), .clr(clr), .err_sticky(sticky_a), .s(ifa));
    gray_bin_stream #(.WIDTH(8)) dut_b (.clk(clk), .rst_n(rst_n), .clr(clr), .err_sticky(sticky_b), .s(ifb));

`ifdef GRAY_ADJ_CHECK_EN
    assign adj_a = ifa.out_adj_err;
    assign adj_b = ifb.out_adj_err;
`else
    assign adj_a = 1'b0;
    assign adj_b = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] g2b(input logic [31:0] g);
        logic [31:0] b = 0;
        for (int i = 0; i < 32; i++) b = b ^ (g >> i);
        return b;
    endfunction

    function automatic logic [31:0] b2g(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // reference: the word currently held for the sink, plus last mode-0 word seen
    logic        pv[2], pm[2], pa[2], hv[2], st[2];
    logic [31:0] pd[2], hist[2];

    task automatic model_step(input int k, input logic rstn, input logic clrv,
                              input logic iv, input logic ir, input logic [31:0] id, input logic im,
                              input logic ov, input logic orr, input logic [31:0] od, input logic om,
                              input logic oadj, input logic sticky);
        logic fire_in, fire_out, adj;
        if (!rstn) begin
            pv[k] = 0; pm[k] = 0; pa[k] = 0; hv[k] = 0; st[k] = 0; pd[k] = 0; hist[k] = 0;
            return;
        end
        check($sformatf("%0d.out_valid", k), 32'(ov), 32'(pv[k]));
        check($sformatf("%0d.in_ready", k), 32'(ir), 32'(!pv[k] || orr));
        check($sformatf("%0d.out_data", k), od, pd[k]);
        check($sformatf("%0d.out_mode", k), 32'(om), 32'(pm[k]));
`ifdef GRAY_ADJ_CHECK_EN
        check($sformatf("%0d.out_adj_err", k), 32'(oadj), 32'(pa[k]));
        check($sformatf("%0d.err_sticky", k), 32'(sticky), 32'(st[k]));
`else
        check($sformatf("%0d.err_sticky", k), 32'(sticky), 0);
`endif
        fire_in  = iv && (!pv[k] || orr);
        fire_out = pv[k] && orr;
        adj = 1'b0;
        if (fire_in) begin
            if (im) begin
                hv[k] = 0;
            end else begin
                adj = hv[k] && !clrv && ($countones(id ^ hist[k]) != 1);
                hist[k] = id;
                hv[k] = 1;
            end
            pd[k] = im ? b2g(id) : g2b(id);
            pm[k] = im; pa[k] = adj; pv[k] = 1;
        end else if (fire_out) begin
            pv[k] = 0;
        end
        if (clrv) begin
            st[k] = 0;
            if (!(fire_in && !im)) hv[k] = 0;
        end else if (adj) begin
            st[k] = 1;
        end
    endtask

    always @(negedge clk) begin
        model_step(0, rst_n, clr, ifa.in_valid, ifa.in_ready, 32'(ifa.in_data), ifa.in_mode,
                   ifa.out_valid, ifa.out_ready, 32'(ifa.out_data), ifa.out_mode, adj_a, sticky_a);
        model_step(1, rst_n, clr, ifb.in_valid, ifb.in_ready, 32'(ifb.in_data), ifb.in_mode,
                   ifb.out_valid, ifb.out_ready, 32'(ifb.out_data), ifb.out_mode, adj_b, sticky_b);
    end

    task automatic step_a(input logic v, input logic [2:0] d, input logic m);
        ifa.in_valid = v; ifa.in_data = d; ifa.in_mode = m;
        @(posedge clk); #1;
    endtask

    logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    logic [7:0] cur, g;
    int acc, cyc;

    initial begin
        ifa.in_valid = 0; ifa.in_data = 0; ifa.in_mode = 0; ifa.out_ready = 1;
        ifb.in_valid = 0; ifb.in_data = 0; ifb.in_mode = 0; ifb.out_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        check("rst_out_valid", 32'(ifa.out_valid), 0);
        check("rst_out_data", 32'(ifa.out_data), 0);
        check("rst_in_ready", 32'(ifa.in_ready), 1);
        check("rst_sticky", 32'(sticky_a), 0);

        for (int i = 0; i < 8; i++) begin
            step_a(1, gseq[i], 0);
            check("g2b_seq_data", 32'(ifa.out_data), i);
            check("g2b_seq_valid", 32'(ifa.out_valid), 1);
`ifdef GRAY_ADJ_CHECK_EN
            check("g2b_seq_adj", 32'(adj_a), 0);
`endif
        end

        step_a(1, 3'b101, 1);
        check("b2g_101", 32'(ifa.out_data), 7);
        check("b2g_101_mode", 32'(ifa.out_mode), 1);
        step_a(1, 3'b011, 1);
        check("b2g_011", 32'(ifa.out_data), 2);
        step_a(1, 3'b100, 0);
        check("g2b_100", 32'(ifa.out_data), 7);
        check("g2b_100_mode", 32'(ifa.out_mode), 0);

        step_a(1, 3'b110, 1);
        check("bp_load", 32'(ifa.out_data), 5);
        ifa.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step_a(1, 3'b000, 0);
            check("bp_in_ready", 32'(ifa.in_ready), 0);
            check("bp_hold_data", 32'(ifa.out_data), 5);
            check("bp_hold_valid", 32'(ifa.out_valid), 1);
        end
        ifa.out_ready = 1;
        step_a(1, 3'b110, 0);
        check("bp_release_data", 32'(ifa.out_data), 4);
        check("bp_release_valid", 32'(ifa.out_valid), 1);
        step_a(0, 3'b000, 0);
        check("drain_valid", 32'(ifa.out_valid), 0);
        check("drain_data_held", 32'(ifa.out_data), 4);

        clr = 1; step_a(0, 3'b000, 0); clr = 0;
        step_a(1, 3'b000, 0);
        step_a(1, 3'b011, 0);
`ifdef GRAY_ADJ_CHECK_EN
        check("adj_two_bits", 32'(adj_a), 1);
        check("adj_sticky_set", 32'(sticky_a), 1);
`endif
        clr = 1; step_a(0, 3'b000, 0); clr = 0;
`ifdef GRAY_ADJ_CHECK_EN
        check("adj_sticky_clr", 32'(sticky_a), 0);
`endif
        step_a(1, 3'b011, 0);
`ifdef GRAY_ADJ_CHECK_EN
        check("adj_first_after_clr", 32'(adj_a), 0);
`endif
        step_a(1, 3'b011, 0);
`ifdef GRAY_ADJ_CHECK_EN
        check("adj_repeat", 32'(adj_a), 1);
`endif

        step_a(1, 3'b001, 0);
        ifa.in_valid = 0;
        #2 rst_n = 0;
        #1;
        check("async_rst_valid", 32'(ifa.out_valid), 0);
        check("async_rst_data", 32'(ifa.out_data), 0);
        check("async_rst_sticky", 32'(sticky_a), 0);
        @(posedge clk); #1 rst_n = 1;
        check("async_rst_in_ready", 32'(ifa.in_ready), 1);

        cur = 8'($urandom_range(255, 0));
        acc = 0; cyc = 0;
        while (acc < 256 && cyc < 5000) begin
            ifb.in_valid = ($urandom_range(3, 0) != 0);
            ifb.in_data = cur; ifb.in_mode = 0;
            ifb.out_ready = ($urandom_range(3, 0) != 0);
            @(negedge clk);
            if (ifb.in_valid && ifb.in_ready) begin
                acc++;
                cur = cur ^ (8'd1 << $urandom_range(7, 0));
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("walk_accepted", acc, 256);

        ifb.out_ready = 1;
        for (int x = 0; x < 256; x++) begin
            ifb.in_valid = 1; ifb.in_data = 8'(x); ifb.in_mode = 1;
            @(posedge clk); #1;
            g = ifb.out_data;
            ifb.in_data = g; ifb.in_mode = 0;
            @(posedge clk); #1;
            check("roundtrip", 32'(ifb.out_data), x);
        end

        for (int i = 0; i < 400; i++) begin
            ifb.in_valid = ($urandom_range(3, 0) != 0);
            ifb.in_mode = 1'($urandom_range(1, 0));
            if ($urandom_range(1, 0) != 0) ifb.in_data = ifb.in_data ^ (8'd1 << $urandom_range(7, 0));
            else ifb.in_data = 8'($urandom_range(255, 0));
            ifb.out_ready = ($urandom_range(2, 0) != 0);
            clr = ($urandom_range(15, 0) == 0);
            @(posedge clk); #1;
        end
        clr = 0; ifb.in_valid = 0; ifb.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
